// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: ID-stage hazard inputs and forward/stall/flush controls, rev 1.0
`default_nettype none

interface hazard_fwd_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_wren;
  logic              id_is_load;
  logic              ex_br_taken;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall_if;
  logic              stall_id;
  logic              flush_id;
  logic              flush_ex;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_wren, id_is_load, ex_br_taken,
    input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_wren, id_is_load, ex_br_taken,
    output fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex
  );
endinterface

`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: RV32I 5-stage forwarding, load-use stall and redirect flush control, rev 1.0
// Optional stall/flush performance counters enabled by defining HAZARD_PERF_CNT_EN.
`default_nettype none

module hazard_fwd_ctrl #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  hazard_fwd_ctrl_if.slave    bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         o_stall_cnt,
  output logic [31:0]         o_flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              rd_wren;
    logic              is_load;
  } rec_t;

  rec_t              ex_q;
  rec_t              mem_q;
  rec_t              wb_q;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              ex_rs1_used;
  logic              ex_rs2_used;

  logic       load_use;
  logic       redirect;
  logic       bubble;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // A stage is a usable producer only if it really writes a non-zero register.
  function automatic logic writes_reg(input rec_t r);
    return r.valid && r.rd_wren && (r.rd != '0) && (int'(r.rd) < NUM_REGS);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_valid, input logic used,
                                         input logic [REG_AW-1:0] rs,
                                         input rec_t mem, input rec_t wb);
    if (!(ex_valid && used))
      return 2'b00;
    if (writes_reg(mem) && (mem.rd == rs))
      return 2'b01;
    if (writes_reg(wb) && (wb.rd == rs))
      return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    sel_a    = fwd_sel(ex_q.valid, ex_rs1_used, ex_rs1, mem_q, wb_q);
    sel_b    = fwd_sel(ex_q.valid, ex_rs2_used, ex_rs2, mem_q, wb_q);
    redirect = bus.ex_br_taken;
    load_use = bus.id_valid && ex_q.is_load && writes_reg(ex_q) &&
               ((bus.id_rs1_used && (bus.id_rs1 == ex_q.rd)) ||
                (bus.id_rs2_used && (bus.id_rs2 == ex_q.rd)));
    bubble   = load_use || redirect;
  end

  // A redirect squashes the wrong-path ID instruction, so it beats the stall.
  assign bus.fwd_a_sel = i_rst_n ? sel_a : 2'b00;
  assign bus.fwd_b_sel = i_rst_n ? sel_b : 2'b00;
  assign bus.stall_if  = i_rst_n && load_use && !redirect;
  assign bus.stall_id  = i_rst_n && load_use && !redirect;
  assign bus.flush_id  = i_rst_n && redirect;
  assign bus.flush_ex  = i_rst_n && bubble;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble) begin
        ex_q.valid <= 1'b0;
      end else begin
        ex_q.valid   <= bus.id_valid;
        ex_q.rd      <= bus.id_rd;
        ex_q.rd_wren <= bus.id_rd_wren;
        ex_q.is_load <= bus.id_is_load;
        ex_rs1       <= bus.id_rs1;
        ex_rs2       <= bus.id_rs2;
        ex_rs1_used  <= bus.id_rs1_used;
        ex_rs2_used  <= bus.id_rs2_used;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (load_use && !redirect && (o_stall_cnt != 32'hFFFF_FFFF))
        o_stall_cnt <= o_stall_cnt + 32'd1;
      if (redirect && (o_flush_cnt != 32'hFFFF_FFFF))
        o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: per-cycle stimulus with expected controls queued and checked mid-cycle.
`default_nettype none

module tb_hazard_fwd_ctrl;

  logic clk;
  logic rst_n;

  hazard_fwd_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_fwd_ctrl #(.REG_AW(5), .NUM_REGS(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       sif;
    logic       sid;
    logic       fid;
    logic       fex;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step_no = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one ID-stage instruction, queue its expected controls, check them mid-cycle.
  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic we, input logic ld, input logic br,
                      input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input logic efid, input logic efex,
                      input logic rst_after);
    exp_t e;
    exp_t got;
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.id_rd       = rd;
    bus.id_rd_wren  = we;
    bus.id_is_load  = ld;
    bus.ex_br_taken = br;
    e.a = ea; e.b = eb; e.sif = es; e.sid = es; e.fid = efid; e.fex = efex;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check_eq($sformatf("s%0d_fwd_a", step_no), 32'(bus.fwd_a_sel), 32'(got.a));
    check_eq($sformatf("s%0d_fwd_b", step_no), 32'(bus.fwd_b_sel), 32'(got.b));
    check_eq($sformatf("s%0d_stall_if", step_no), 32'(bus.stall_if), 32'(got.sif));
    check_eq($sformatf("s%0d_stall_id", step_no), 32'(bus.stall_id), 32'(got.sid));
    check_eq($sformatf("s%0d_flush_id", step_no), 32'(bus.flush_id), 32'(got.fid));
    check_eq($sformatf("s%0d_flush_ex", step_no), 32'(bus.flush_ex), 32'(got.fex));
    step_no++;
    if (rst_after)
      rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0; bus.id_rd = '0;
    bus.id_rd_wren = 1'b0; bus.id_is_load = 1'b0; bus.ex_br_taken = 1'b0;
    @(posedge clk);
    #1;
    // Reset: outputs stay zero even with a redirect request present
    step(1, 3, 3, 1, 1, 4, 1, 0, 1,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
    check_eq("cnt_stall_reset", stall_cnt, 32'd0);
    check_eq("cnt_flush_reset", flush_cnt, 32'd0);
`endif
    // ALU producer then consumer (distance 1)
    step(1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step(1, 5, 3, 1, 1, 6, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    // Distance-2 producer into rs2
    step(1, 1, 2, 1, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step(1, 4, 7, 1, 1, 8, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0);
    // x7 written twice: MEM copy must win
    step(1, 1, 2, 1, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 1, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step(1, 3, 7, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    // lw x3 ; add x4,x3,x1
    step(1, 2, 0, 1, 0, 3, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    step(1, 3, 1, 1, 1, 4, 1, 0, 0,  0, 0, 1, 0, 1, 0);
    step(1, 3, 1, 1, 1, 4, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0);
    // x0 producer/consumer, then load with an unused matching source
    step(1, 1, 2, 1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 1, 0, 9, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    step(1, 9, 1, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Redirect coincident with load-use
    step(1, 1, 0, 1, 0, 13, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 13, 2, 1, 1, 14, 1, 0, 1, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("cnt_stall", stall_cnt, 32'd1);
    check_eq("cnt_flush", flush_cnt, 32'd1);
`endif
    // Reset taken at the edge ending a stall cycle
    step(1, 1, 0, 1, 0, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 15, 2, 1, 1, 16, 1, 0, 0, 0, 0, 1, 0, 1, 1);
    rst_n = 1'b1;
    step(1, 15, 2, 1, 1, 16, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("cnt_stall_after_rst", stall_cnt, 32'd0);
    check_eq("cnt_flush_after_rst", flush_cnt, 32'd0);
`endif
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
